// File: rtl/mips_loader.sv
// rtl/mips_loader.sv - host program loader and register dumper for pipe_MIPS32
// Optional LOADER_CHECKSUM_EN appends an XOR-of-program word (CHECK state) after the dump.
module mips_loader #(
  parameter int ADDR_W     = 10,
  parameter int DUMP_COUNT = 32
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_start,
  input  logic              core_halted,
  output logic [4:0]        reg_addr,
  input  logic [31:0]       reg_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_data,
  output logic              done,
  output logic [ADDR_W:0]   load_count
);

  localparam logic [31:0] HLT      = 32'hfc000000;
  localparam logic [5:0]  LAST_IDX = 6'(DUMP_COUNT - 1);

  typedef enum logic [2:0] {
    S_LOAD,
    S_START,
    S_RUN,
    S_DUMP,
`ifdef LOADER_CHECKSUM_EN
    S_CHECK,
`endif
    S_DONE
  } state_t;

  state_t              state, state_d;
  logic                mem_we_d, core_start_d, out_valid_d, done_d;
  logic [ADDR_W-1:0]   mem_addr_d;
  logic [31:0]         mem_wdata_d, out_data_d;
  logic [4:0]          reg_addr_d;
  logic [ADDR_W:0]     load_count_d;
  logic [5:0]          widx, widx_d;
  logic                accept;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0]         csum, csum_d;
`endif

  assign in_ready = (state == S_LOAD) && !rst;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d      = state;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr;
    mem_wdata_d  = mem_wdata;
    core_start_d = 1'b0;
    reg_addr_d   = reg_addr;
    out_valid_d  = out_valid;
    out_data_d   = out_data;
    done_d       = done;
    load_count_d = load_count;
    widx_d       = widx;
`ifdef LOADER_CHECKSUM_EN
    csum_d       = csum;
`endif
    case (state)
      S_LOAD: begin
        if (accept) begin
          mem_we_d     = 1'b1;
          mem_addr_d   = load_count[ADDR_W-1:0];
          mem_wdata_d  = in_data;
          load_count_d = load_count + (ADDR_W+1)'(1);
`ifdef LOADER_CHECKSUM_EN
          csum_d       = csum ^ in_data;
`endif
          if (in_data == HLT || &load_count[ADDR_W-1:0])
            state_d = S_START;
        end
      end
      S_START: begin
        core_start_d = 1'b1;
        state_d      = S_RUN;
      end
      S_RUN: begin
        // HALTED seen during the start pulse is left over from the previous run
        if (core_halted && !core_start) begin
          state_d    = S_DUMP;
          reg_addr_d = 5'd0;
        end
      end
      S_DUMP: begin
        if (!out_valid) begin
          out_valid_d = 1'b1;
          out_data_d  = reg_rdata;
          reg_addr_d  = reg_addr + 5'd1;
          widx_d      = 6'd0;
        end else if (out_ready) begin
          if (widx == LAST_IDX) begin
`ifdef LOADER_CHECKSUM_EN
            out_data_d  = csum;
            state_d     = S_CHECK;
`else
            out_valid_d = 1'b0;
            out_data_d  = 32'd0;
            done_d      = 1'b1;
            state_d     = S_DONE;
`endif
          end else begin
            out_data_d  = reg_rdata;
            reg_addr_d  = reg_addr + 5'd1;
            widx_d      = widx + 6'd1;
          end
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          out_data_d  = 32'd0;
          done_d      = 1'b1;
          state_d     = S_DONE;
        end
      end
`endif
      S_DONE: begin
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      state      <= S_LOAD;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= 32'd0;
      core_start <= 1'b0;
      reg_addr   <= 5'd0;
      out_valid  <= 1'b0;
      out_data   <= 32'd0;
      done       <= 1'b0;
      load_count <= '0;
      widx       <= 6'd0;
`ifdef LOADER_CHECKSUM_EN
      csum       <= 32'd0;
`endif
    end else begin
      state      <= state_d;
      mem_we     <= mem_we_d;
      mem_addr   <= mem_addr_d;
      mem_wdata  <= mem_wdata_d;
      core_start <= core_start_d;
      reg_addr   <= reg_addr_d;
      out_valid  <= out_valid_d;
      out_data   <= out_data_d;
      done       <= done_d;
      load_count <= load_count_d;
      widx       <= widx_d;
`ifdef LOADER_CHECKSUM_EN
      csum       <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_mips_loader.sv
// tb/tb_mips_loader.sv - self-checking bench for mips_loader with a behavioural core model
module tb_mips_loader;
  localparam int AW = 6, DC = 6, SAW = 3;
  localparam logic [31:0] HLT = 32'hfc000000;

  logic clk1 = 1'b0;
  always #5 clk1 = ~clk1;
  logic rst = 1'b1;

  logic in_valid = 1'b0, in_ready, mem_we, core_start, core_halted, out_valid, out_ready = 1'b0, done;
  logic [31:0] in_data = 32'd0, mem_wdata, reg_rdata, out_data;
  logic [AW-1:0] mem_addr;
  logic [4:0] reg_addr;
  logic [AW:0] load_count;

  logic s_in_valid = 1'b0, s_in_ready, s_mem_we, s_core_start, s_out_valid, s_done;
  logic [31:0] s_in_data = 32'd0, s_mem_wdata, s_out_data;
  logic [SAW-1:0] s_mem_addr;
  logic [4:0] s_reg_addr;
  logic [SAW:0] s_load_count;

  mips_loader #(.ADDR_W(AW), .DUMP_COUNT(DC)) u_dut (
    .clk1(clk1), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .core_start(core_start),
    .core_halted(core_halted), .reg_addr(reg_addr), .reg_rdata(reg_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .done(done),
    .load_count(load_count));

  mips_loader #(.ADDR_W(SAW), .DUMP_COUNT(DC)) u_small (
    .clk1(clk1), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata), .core_start(s_core_start),
    .core_halted(1'b0), .reg_addr(s_reg_addr), .reg_rdata(32'd0),
    .out_valid(s_out_valid), .out_ready(1'b1), .out_data(s_out_data), .done(s_done),
    .load_count(s_load_count));

  // core model: instruction memory, register file, HALTED after a programmable delay
  logic [31:0] mem_m [0:(1<<AW)-1];
  logic [31:0] regs [0:31];
  logic halted_m = 1'b0, hold_halt = 1'b0, rand_regs = 1'b0;
  int cd = 0, core_delay = 4;
  assign core_halted = halted_m | hold_halt;
  assign reg_rdata = regs[reg_addr];

  task automatic core_exec();
    logic [31:0] w;
    logic [AW-1:0] pa;
    for (int i = 0; i < 32; i++) regs[i] = rand_regs ? $urandom : 32'd0;
    if (!rand_regs) begin
      for (int pc = 0; pc < (1 << AW); pc++) begin
        pa = AW'(pc);
        w = mem_m[pa];
        if (w[31:26] == 6'h3f) break;
        case (w[31:26])
          6'h00: regs[w[15:11]] = regs[w[25:21]] + regs[w[20:16]];
          6'h03: regs[w[15:11]] = regs[w[25:21]] | regs[w[20:16]];
          6'h0a: regs[w[20:16]] = regs[w[25:21]] + {{16{w[15]}}, w[15:0]};
          default: ;
        endcase
      end
    end
  endtask

  always @(posedge clk1) begin
    if (mem_we) mem_m[mem_addr] <= mem_wdata;
    if (core_start) begin
      halted_m <= 1'b0;
      core_exec();
      cd <= core_delay;
    end else if (!halted_m && cd > 0) begin
      cd <= cd - 1;
      if (cd == 1) halted_m <= 1'b1;
    end
  end

  int starts = 0, s_starts = 0;
  always @(negedge clk1) begin
    if (core_start) starts++;
    if (s_core_start) s_starts++;
  end

  int n_cmp = 0, n_fail = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  typedef struct { logic [31:0] word; logic [31:0] dump; } vec_t;
  vec_t tbl [9];
  logic [31:0] prog_q[$], exp_q[$], got_q[$];

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; s_in_valid = 1'b0;
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_core_start", 32'(core_start), 32'd0);
    chk("rst_reg_addr", 32'(reg_addr), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_load_count", 32'(load_count), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic load_prog(input bit gaps);
    for (int k = 0; k < prog_q.size(); k++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        tick();
        chk("idle_mem_we", 32'(mem_we), 32'd0);
      end
      in_valid = 1'b1; in_data = prog_q[k];
      tick();
      in_valid = 1'b0; in_data = $urandom;
      chk($sformatf("we_%0d", k), 32'(mem_we), 32'd1);
      chk($sformatf("addr_%0d", k), 32'(mem_addr), k);
      chk($sformatf("wdata_%0d", k), mem_wdata, prog_q[k]);
      chk($sformatf("lcnt_%0d", k), 32'(load_count), k + 1);
    end
  endtask

  task automatic after_load();
    chk("start_n1", 32'(core_start), 32'd0);
    tick();
    chk("start_n2", 32'(core_start), 32'd1);
    chk("ready_n2", 32'(in_ready), 32'd0);
    tick();
    chk("start_n3", 32'(core_start), 32'd0);
  endtask

  task automatic collect(input int max_words, input int mode);
    logic stalled;
    logic [31:0] held;
    int ph;
    stalled = 1'b0; held = 32'd0; ph = 0;
    got_q.delete();
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (stalled) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", out_data, held);
      end
      if (out_valid && got_q.size() < DC) chk("reg_lead", 32'(reg_addr), got_q.size() + 1);
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = (ph % 2 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (out_valid) ph++;
      if (out_valid && out_ready) got_q.push_back(out_data);
      stalled = out_valid && !out_ready;
      held = out_data;
      tick();
      if (got_q.size() >= max_words) break;
    end
    out_ready = 1'b0;
    if (got_q.size() < max_words) chk("dump_timeout", got_q.size(), max_words);
  endtask

  task automatic dump_check(input int mode, input string tag);
    collect(exp_q.size(), mode);
    for (int i = 0; i < exp_q.size(); i++)
      chk($sformatf("%s_word%0d", tag, i), (i < got_q.size()) ? got_q[i] : 32'hdeadbeef, exp_q[i]);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_valid_low"}, 32'(out_valid), 32'd0);
    tick(); tick();
    chk({tag, "_done_sticky"}, 32'(done), 32'd1);
    chk({tag, "_no_extra"}, 32'(out_valid), 32'd0);
  endtask

  task automatic exp_from(input bit use_regs);
    logic [31:0] x;
    exp_q.delete();
    for (int i = 0; i < DC; i++) exp_q.push_back(use_regs ? regs[i] : tbl[i].dump);
    x = 32'd0;
    foreach (prog_q[i]) x ^= prog_q[i];
`ifdef LOADER_CHECKSUM_EN
    exp_q.push_back(x);
`endif
  endtask

  task automatic sum_prog();
    prog_q.delete();
    for (int i = 0; i < 9; i++) prog_q.push_back(tbl[i].word);
    rand_regs = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int st0;
    logic [31:0] w;
    tbl[0] = '{32'h2801000a, 32'd0};   tbl[1] = '{32'h28020014, 32'd10};
    tbl[2] = '{32'h28030019, 32'd20};  tbl[3] = '{32'h0ce77800, 32'd25};
    tbl[4] = '{32'h0ce77800, 32'd30};  tbl[5] = '{32'h00222000, 32'd55};
    tbl[6] = '{32'h0ce77800, 32'd0};   tbl[7] = '{32'h00832800, 32'd0};
    tbl[8] = '{32'hfc000000, 32'd0};

    do_reset();

    // memory-full on the 8-word instance, no HLT in the stream
    for (int k = 0; k < 10; k++) begin
      s_in_valid = 1'b1; s_in_data = k + 1;
      tick();
      if (k < 8) begin
        chk($sformatf("full_we_%0d", k), 32'(s_mem_we), 32'd1);
        chk($sformatf("full_addr_%0d", k), 32'(s_mem_addr), k);
        chk($sformatf("full_lcnt_%0d", k), 32'(s_load_count), k + 1);
      end else begin
        chk($sformatf("full_we_%0d", k), 32'(s_mem_we), 32'd0);
      end
      if (k >= 7) chk($sformatf("full_ready_%0d", k), 32'(s_in_ready), 32'd0);
    end
    s_in_valid = 1'b0;
    tick();
    chk("full_lcnt", 32'(s_load_count), 32'd8);
    chk("full_start_pulses", s_starts, 32'd1);
    chk("full_last_wdata", s_mem_wdata, 32'd8);
    chk("full_idle_outs", {s_out_data[30:0], s_out_valid}, 32'd0);
    chk("full_idle_misc", {25'd0, s_done, 1'b0, s_reg_addr}, 32'd0);

    // sum program, no backpressure
    do_reset(); sum_prog(); core_delay = 5; st0 = starts;
    load_prog(1'b0);
    chk("sum_load_count", 32'(load_count), 32'd9);
    after_load();
    chk("sum_one_start", starts - st0, 32'd1);
    exp_from(1'b0);
    dump_check(0, "sum");

    // same program, out_ready toggling 1010
    do_reset(); sum_prog(); core_delay = 3;
    load_prog(1'b0); after_load(); exp_from(1'b0);
    dump_check(1, "tog");

    // stale HALTED held through the start pulse
    hold_halt = 1'b1;
    do_reset(); sum_prog();
    load_prog(1'b0); after_load();
    tick();
    chk("stale_n4_valid", 32'(out_valid), 32'd0);
    chk("stale_n4_reg_addr", 32'(reg_addr), 32'd0);
    tick();
    chk("stale_n5_valid", 32'(out_valid), 32'd1);
    chk("stale_n5_data", out_data, tbl[0].dump);
    hold_halt = 1'b0;
    exp_from(1'b0);
    dump_check(0, "stale");

    // reset after three dump words, then reload and rerun
    do_reset(); sum_prog(); core_delay = 4;
    load_prog(1'b0); after_load();
    collect(3, 0);
    for (int i = 0; i < 3; i++)
      chk($sformatf("part_word%0d", i), (i < got_q.size()) ? got_q[i] : 32'hdeadbeef, tbl[i].dump);
    do_reset();
    st0 = starts; hold_halt = 1'b1;
    repeat (10) tick();
    chk("abort_no_restart", starts - st0, 32'd0);
    chk("abort_no_dump", 32'(out_valid), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    hold_halt = 1'b0;
    load_prog(1'b0); after_load(); exp_from(1'b0);
    dump_check(0, "rld");

    // random programs, input gaps, random backpressure, random register contents
    for (int it = 0; it < 3; it++) begin
      do_reset();
      prog_q.delete();
      for (int n = $urandom_range(1, 40); n > 0; n--) begin
        w = $urandom;
        if (w == HLT) w ^= 32'd1;
        prog_q.push_back(w);
      end
      prog_q.push_back(HLT);
      rand_regs = 1'b1; core_delay = $urandom_range(1, 12);
      load_prog(1'b1); after_load(); exp_from(1'b1);
      dump_check(2, $sformatf("rnd%0d", it));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
